// File: rtl/mac_tile_dual_if.sv
// Bundle of the per-tile data/instruction signals of one systolic PE.
// The array controller drives the master side; each tile uses the slave side.
interface mac_tile_dual_if #(
  parameter int bw      = 4,
  parameter int psum_bw = 16
);
  logic                mode;
  logic [bw-1:0]       in_w;
  logic [2:0]          inst_w;
  logic [psum_bw-1:0]  in_n;
  logic [bw-1:0]       out_e;
  logic [2:0]          inst_e;
  logic [psum_bw-1:0]  out_s;

  modport master (
    output mode, in_w, inst_w, in_n,
    input  out_e, inst_e, out_s
  );

  modport slave (
    input  mode, in_w, inst_w, in_n,
    output out_e, inst_e, out_s
  );
endinterface

// File: rtl/mac_tile_dual.sv
// Dual-mode systolic PE: weight-stationary (psum passes through) or
// output-stationary (local accumulator, drained down the column as a shift chain).
module mac_tile_dual #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int SAT     = 0
) (
  input logic           clk,
  input logic           reset,
  mac_tile_dual_if.slave tile
);

  logic signed [bw-1:0]      a_q, a_d, b_q, b_d;
  logic signed [psum_bw-1:0] c_q, c_d, acc_q, acc_d;
  logic [2:0]                inst_q, inst_d;
  logic                      load_ready_q, load_ready_d;
  logic                      mode_q, mode_d;

  logic signed [psum_bw-1:0] ws_sum, os_prod, out_s_sel;

  function automatic logic signed [psum_bw-1:0] prod(
    input logic signed [bw-1:0] x,
    input logic signed [bw-1:0] y
  );
    logic signed [2*bw-1:0] xe, ye, pf;
    xe = (2*bw)'(x);
    ye = (2*bw)'(y);
    pf = xe * ye;
    return psum_bw'(pf);
  endfunction

  // One extra bit exposes overflow; SAT clamps instead of wrapping.
  function automatic logic signed [psum_bw-1:0] sadd(
    input logic signed [psum_bw-1:0] x,
    input logic signed [psum_bw-1:0] y
  );
    logic signed [psum_bw:0] s;
    logic signed [psum_bw-1:0] r;
    s = (psum_bw+1)'(x) + (psum_bw+1)'(y);
    if ((SAT != 32'sd0) && (s[psum_bw] != s[psum_bw-1])) begin
      r = s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
    end else begin
      r = s[psum_bw-1:0];
    end
    return r;
  endfunction

  assign ws_sum  = sadd(c_q, prod(a_q, b_q));
  assign os_prod = prod(tile.in_w, tile.in_n[bw-1:0]);

  // South output: WS psum, or OS drained accumulator / forwarded weight
  always_comb begin
    out_s_sel = ws_sum;
    if (mode_q) begin
      out_s_sel = tile.inst_w[2] ? acc_q : psum_bw'(b_q);
    end else begin
      out_s_sel = ws_sum;
    end
  end

  // Next-state logic for both modes; a mode change overrides the instruction
  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    acc_d        = acc_q;
    inst_d       = inst_q;
    load_ready_d = load_ready_q;
    mode_d       = mode_q;
    if (tile.mode != mode_q) begin
      mode_d       = tile.mode;
      acc_d        = '0;
      load_ready_d = 1'b1;
      inst_d       = 3'b000;
    end else if (!mode_q) begin
      // A load is absorbed while armed; once consumed, later loads pass east.
      b_d          = (tile.inst_w[0] && load_ready_q) ? $signed(tile.in_w) : b_q;
      inst_d       = {tile.inst_w[2], tile.inst_w[1], tile.inst_w[0] & ~load_ready_q};
      load_ready_d = tile.inst_w[2] | (load_ready_q & ~tile.inst_w[0]);
      if (tile.inst_w[1]) begin
        a_d = tile.in_w;
        c_d = tile.in_n;
      end else begin
        a_d = a_q;
        c_d = c_q;
      end
    end else begin
      inst_d = tile.inst_w;
      if (tile.inst_w[2]) begin
        acc_d = tile.in_n;
      end else if (tile.inst_w[0] && tile.inst_w[1]) begin
        acc_d = os_prod;
      end else if (tile.inst_w[0]) begin
        acc_d = '0;
      end else if (tile.inst_w[1]) begin
        acc_d = sadd(acc_q, os_prod);
      end else begin
        acc_d = acc_q;
      end
      if (!tile.inst_w[2] && tile.inst_w[1]) begin
        a_d = tile.in_w;
        b_d = tile.in_n[bw-1:0];
      end else begin
        a_d = a_q;
        b_d = b_q;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      acc_q        <= '0;
      inst_q       <= 3'b000;
      load_ready_q <= 1'b1;
      mode_q       <= 1'b0;
    end else begin
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      acc_q        <= acc_d;
      inst_q       <= inst_d;
      load_ready_q <= load_ready_d;
      mode_q       <= mode_d;
    end
  end

  assign tile.out_e  = a_q;
  assign tile.inst_e = inst_q;
  assign tile.out_s  = out_s_sel;

endmodule

// File: tb/tb_mac_tile_dual.sv
// Self-checking bench: one main tile tracked by a behavioural model, a saturating
// tile, and a 3-tile column for the drain shift chain.
module tb_mac_tile_dual;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_tile_dual_if #(.bw(4), .psum_bw(16)) u_if ();
  mac_tile_dual_if #(.bw(4), .psum_bw(16)) s_if ();
  mac_tile_dual_if #(.bw(4), .psum_bw(16)) c0_if ();
  mac_tile_dual_if #(.bw(4), .psum_bw(16)) c1_if ();
  mac_tile_dual_if #(.bw(4), .psum_bw(16)) c2_if ();

  mac_tile_dual #(.bw(4), .psum_bw(16), .SAT(0)) u_dut  (.clk(clk), .reset(reset), .tile(u_if.slave));
  mac_tile_dual #(.bw(4), .psum_bw(16), .SAT(1)) s_dut  (.clk(clk), .reset(reset), .tile(s_if.slave));
  mac_tile_dual #(.bw(4), .psum_bw(16), .SAT(0)) c0_dut (.clk(clk), .reset(reset), .tile(c0_if.slave));
  mac_tile_dual #(.bw(4), .psum_bw(16), .SAT(0)) c1_dut (.clk(clk), .reset(reset), .tile(c1_if.slave));
  mac_tile_dual #(.bw(4), .psum_bw(16), .SAT(0)) c2_dut (.clk(clk), .reset(reset), .tile(c2_if.slave));

  assign c1_if.in_n = c0_if.out_s;
  assign c2_if.in_n = c1_if.out_s;

  int passed = 0;
  int total  = 0;

  // reference model of the main tile
  int       m_a, m_b, m_c, m_acc;
  logic [2:0] m_inst;
  bit       m_lr, m_mode;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int fold(input longint s, input bit sat);
    logic signed [15:0] t;
    if (sat) begin
      if (s > 32767) return 32767;
      if (s < -32768) return -32768;
      return int'(s);
    end
    t = 16'(s);
    return int'(t);
  endfunction

  function automatic logic [15:0] exp_out_s();
    if (!m_mode) return 16'(fold(longint'(m_c + m_a * m_b), 1'b0));
    if (u_if.inst_w[2]) return 16'(m_acc);
    return 16'(m_b);
  endfunction

  task automatic check_u();
    logic [3:0] ea;
    ea = 4'(m_a);
    chk("u_out_e", {12'd0, u_if.out_e}, {12'd0, ea});
    chk("u_inst_e", {13'd0, u_if.inst_e}, {13'd0, m_inst});
    chk("u_out_s", u_if.out_s, exp_out_s());
  endtask

  task automatic model_edge();
    int w, n, nl, p;
    logic [2:0] iw;
    bit lr_old;
    w  = int'($signed(u_if.in_w));
    n  = int'($signed(u_if.in_n));
    nl = int'($signed(u_if.in_n[3:0]));
    iw = u_if.inst_w;
    p  = w * nl;
    if (reset) begin
      m_a = 0; m_b = 0; m_c = 0; m_acc = 0; m_inst = 3'b000; m_lr = 1'b1; m_mode = 1'b0;
    end else if (u_if.mode != m_mode) begin
      m_mode = u_if.mode; m_acc = 0; m_lr = 1'b1; m_inst = 3'b000;
    end else if (!m_mode) begin
      lr_old = m_lr;
      if (iw[0] && lr_old) begin m_b = w; m_lr = 1'b0; end
      m_inst = {iw[2], iw[1], iw[0] & !lr_old};
      if (iw[1]) begin m_a = w; m_c = n; end
      if (iw[2]) m_lr = 1'b1;
    end else begin
      m_inst = iw;
      if (iw[2]) m_acc = n;
      else begin
        if (iw[1]) begin m_a = w; m_b = nl; end
        if (iw[0]) m_acc = iw[1] ? p : 0;
        else if (iw[1]) m_acc = fold(longint'(m_acc + p), 1'b0);
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_u();
  endtask

  task automatic adv();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc();
    sample();
    adv();
  endtask

  task automatic setu(input logic md, input logic [2:0] iw, input logic [3:0] w, input logic [15:0] n);
    u_if.mode = md; u_if.inst_w = iw; u_if.in_w = w; u_if.in_n = n;
  endtask

  task automatic sets(input logic md, input logic [2:0] iw, input logic [3:0] w, input logic [15:0] n);
    s_if.mode = md; s_if.inst_w = iw; s_if.in_w = w; s_if.in_n = n;
  endtask

  task automatic setc(input logic md, input logic [2:0] iw, input logic [3:0] w0,
                      input logic [3:0] w1, input logic [3:0] w2, input logic [15:0] n0);
    c0_if.mode = md; c1_if.mode = md; c2_if.mode = md;
    c0_if.inst_w = iw; c1_if.inst_w = iw; c2_if.inst_w = iw;
    c0_if.in_w = w0; c1_if.in_w = w1; c2_if.in_w = w2;
    c0_if.in_n = n0;
  endtask

  initial begin
    m_a = 0; m_b = 0; m_c = 0; m_acc = 0; m_inst = 3'b000; m_lr = 1'b1; m_mode = 1'b0;
    reset = 1'b1;
    setu(1'b0, 3'b000, 4'd0, 16'd0);
    sets(1'b0, 3'b000, 4'd0, 16'd0);
    setc(1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 16'd0);
    adv(); adv();
    reset = 1'b0;

    // reset state
    sample();
    chk("rst_out_e", {12'd0, u_if.out_e}, 16'd0);
    chk("rst_inst_e", {13'd0, u_if.inst_e}, 16'd0);
    chk("rst_out_s", u_if.out_s, 16'd0);
    adv();

    // WS load then execute
    setu(1'b0, 3'b001, 4'd3, 16'd0);  cyc();
    setu(1'b0, 3'b010, 4'hE, 16'd10); sample();
    chk("ws_load_absorbed", {13'd0, u_if.inst_e}, 16'd0); adv();
    setu(1'b0, 3'b001, 4'd0, 16'd0);  sample();
    chk("ws_out_s_4", u_if.out_s, 16'd4);
    chk("ws_out_e", {12'd0, u_if.out_e}, 16'h000E); adv();
    setu(1'b0, 3'b100, 4'd0, 16'd0);  sample();
    chk("ws_second_load_fwd", {13'd0, u_if.inst_e}, 16'd1); adv();
    setu(1'b0, 3'b001, 4'd5, 16'd0);  cyc();
    setu(1'b0, 3'b001, 4'd1, 16'd0);  sample();
    chk("ws_rearm_b5", u_if.out_s, 16'd0);
    chk("ws_rearm_absorbed", {13'd0, u_if.inst_e}, 16'd0); adv();
    setu(1'b0, 3'b000, 4'd0, 16'd0);  sample();
    chk("ws_b_held", u_if.out_s, 16'd0);
    chk("ws_load_fwd", {13'd0, u_if.inst_e}, 16'd1); adv();

    // OS accumulate
    setu(1'b1, 3'b000, 4'd0, 16'd0);  cyc();
    setu(1'b1, 3'b011, 4'd2, 16'd3);  cyc();
    setu(1'b1, 3'b010, 4'hF, 16'd4);  sample();
    chk("os_fwd_w3", u_if.out_s, 16'd3); adv();
    setu(1'b1, 3'b010, 4'd7, 16'd7);  sample();
    chk("os_fwd_w4", u_if.out_s, 16'd4); adv();
    setu(1'b1, 3'b100, 4'd0, 16'd100); sample();
    chk("os_acc_51", u_if.out_s, 16'd51); adv();
    setu(1'b1, 3'b110, 4'd3, 16'd2);  sample();
    chk("os_drain_shift", u_if.out_s, 16'd100); adv();
    setu(1'b1, 3'b100, 4'd0, 16'd0);  sample();
    chk("os_drain_exec_acc", u_if.out_s, 16'd2);
    chk("os_drain_holds_a", {12'd0, u_if.out_e}, 16'd7); adv();

    // mode switches: acc cleared, instruction ignored, load re-armed
    setu(1'b1, 3'b010, 4'd5, 16'd5);  cyc();
    setu(1'b0, 3'b000, 4'd0, 16'd0);  cyc();
    setu(1'b1, 3'b011, 4'd7, 16'd7);  cyc();
    setu(1'b1, 3'b100, 4'd0, 16'd0);  sample();
    chk("sw_acc_zero", u_if.out_s, 16'd0);
    chk("sw_inst_zero", {13'd0, u_if.inst_e}, 16'd0);
    chk("sw_inst_ignored", {12'd0, u_if.out_e}, 16'd5); adv();
    setu(1'b0, 3'b000, 4'd0, 16'd0);  cyc();
    setu(1'b0, 3'b001, 4'd6, 16'd0);  cyc();
    setu(1'b0, 3'b000, 4'd0, 16'd0);  sample();
    chk("sw_rearmed", {13'd0, u_if.inst_e}, 16'd0);
    chk("sw_c_held", u_if.out_s, 16'd40); adv();

    // reset during a drain
    setu(1'b1, 3'b000, 4'd0, 16'd0);  cyc();
    setu(1'b1, 3'b011, 4'd3, 16'd3);  cyc();
    setu(1'b1, 3'b100, 4'd0, 16'd0);  reset = 1'b1; sample();
    chk("pre_rst_acc", u_if.out_s, 16'd9); adv();
    reset = 1'b0;
    setu(1'b0, 3'b000, 4'd0, 16'd0);  sample();
    chk("mid_rst_out_e", {12'd0, u_if.out_e}, 16'd0);
    chk("mid_rst_inst_e", {13'd0, u_if.inst_e}, 16'd0);
    chk("mid_rst_out_s", u_if.out_s, 16'd0); adv();

    // saturation (s tile) vs wrap (u tile), same stimulus
    setu(1'b1, 3'b000, 4'd0, 16'd0);  sets(1'b1, 3'b000, 4'd0, 16'd0); cyc();
    setu(1'b1, 3'b100, 4'd0, 16'd32760); sets(1'b1, 3'b100, 4'd0, 16'd32760); cyc();
    setu(1'b1, 3'b010, 4'd7, 16'd7);  sets(1'b1, 3'b010, 4'd7, 16'd7); cyc();
    setu(1'b1, 3'b100, 4'd0, 16'h8008); sets(1'b1, 3'b100, 4'd0, 16'h8008); sample();
    chk("sat_max", s_if.out_s, 16'h7FFF);
    chk("wrap_max", u_if.out_s, 16'h8029); adv();
    setu(1'b1, 3'b010, 4'd7, 16'hFFF9); sets(1'b1, 3'b010, 4'd7, 16'hFFF9); cyc();
    setu(1'b1, 3'b100, 4'd0, 16'd0);  sets(1'b1, 3'b100, 4'd0, 16'd0); sample();
    chk("sat_min", s_if.out_s, 16'h8000);
    chk("wrap_min", u_if.out_s, 16'h7FD7); adv();
    setu(1'b1, 3'b000, 4'd0, 16'd0);  sets(1'b1, 3'b000, 4'd0, 16'd0);

    // column drain: accumulators 5/6/7 top to bottom
    setc(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 16'd0); cyc();
    setc(1'b1, 3'b010, 4'd0, 4'd0, 4'd0, 16'd1); cyc(); cyc();
    setc(1'b1, 3'b011, 4'd5, 4'd6, 4'd7, 16'd1); cyc();
    setc(1'b1, 3'b100, 4'd0, 4'd0, 4'd0, 16'd0); sample();
    chk("col_drain_0", c2_if.out_s, 16'd7); adv();
    sample(); chk("col_drain_1", c2_if.out_s, 16'd6); adv();
    sample(); chk("col_drain_2", c2_if.out_s, 16'd5); adv();
    setc(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 16'd0);

    // random traffic on the main tile against the model
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        u_if.mode   = ~u_if.mode;
        u_if.inst_w = 3'b000;
      end else begin
        u_if.inst_w = 3'($urandom_range(0, 7));
      end
      u_if.in_w = 4'($urandom);
      u_if.in_n = 16'($urandom);
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mac_tile_dual.md
# mac_tile_dual

Dual-mode systolic processing element, the parametrised successor of the weight-stationary MAC tile. It supports weight-stationary (WS) operation and output-stationary (OS) operation, selected by a `mode` port. OS operation adds an internal accumulator, an accumulator clear, and a vertical drain shift chain. Tiles are instantiated row × column in the systolic array. Activations and instructions flow west→east; partial sums, OS weights and drained results flow north→south.

## Interface
- `bw`, 4: activation/weight width, signed two's complement.
- `psum_bw`, 16: partial-sum/accumulator width; must satisfy `psum_bw >= 2*bw`.
- `SAT`, 0: 0 = additions wrap modulo 2^psum_bw; 1 = additions saturate to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mode`  in  1  0 = WS, 1 = OS; sampled every cycle into `mode_q`.
- `in_w`  in  bw  activation (WS: also weight during load).
- `inst_w`  in  3  [0] load (WS) / clear (OS); [1] execute; [2] rearm (WS) / drain (OS).
- `in_n`  in  psum_bw  WS: incoming psum; OS: weight in `[bw-1:0]` during execute, upstream accumulator during drain.
- `out_e`  out  bw  = `a_q`.
- `inst_e`  out  3  = `inst_q`.
- `out_s`  out  psum_bw  WS psum, OS forwarded weight, or drained accumulator.

## Operation
- State: `a_q`, `b_q` (bw); `c_q`, `acc_q` (psum_bw); `inst_q` (3); `load_ready_q`; `mode_q`.
- Product `p` = signed(a) × signed(b), 2*bw bits, sign-extended to psum_bw. Each add is wrap or saturate according to `SAT`.
- **Mode change:** if `mode != mode_q`:
  - `mode_q <= mode`, `acc_q <= 0`, `load_ready_q <= 1`, `inst_q <= 0`.
  - `inst_w` is ignored in that cycle.
  - The controller changes `mode` only while `inst_w == 0`.
- **WS mode (`mode_q = 0`):**
  - Load:
    - If `inst_w[0] & load_ready_q`: `b_q <= in_w`, `load_ready_q <= 0`, and `inst_q[0] <= 0` (the load token is absorbed).
    - Otherwise, if `!load_ready_q`: `inst_q[0] <= inst_w[0]`.
    - Otherwise `inst_q[0] <= 0`.
  - Execute: if `inst_w[1]`: `a_q <= in_w`, `c_q <= in_n`.
  - Rearm: if `inst_w[2]`: `load_ready_q <= 1`. `b_q` is held until the next load. Rearm in the same cycle as a load is applied after the load, so `load_ready_q` ends at 1.
  - `inst_q[1] <= inst_w[1]`, `inst_q[2] <= inst_w[2]`.
  - `out_s = c_q + p(a_q, b_q)`, combinational from registers.
- **OS mode (`mode_q = 1`):**
  - Priority: drain > clear > execute.
  - Drain (`inst_w[2]`):
    - `out_s = acc_q` (combinational select on `inst_w[2]`), `acc_q <= in_n`.
    - `a_q` and `b_q` are held; the execute and clear bits in the same cycle are ignored.
  - Clear without execute: `acc_q <= 0`.
  - Clear with execute: `acc_q <= p(in_w, in_n[bw-1:0])`.
  - Execute alone: `acc_q <= acc_q + p(in_w, in_n[bw-1:0])`.
  - Execute (with or without clear) also captures `a_q <= in_w` and `b_q <= in_n[bw-1:0]`.
  - When not draining: `out_s = {(psum_bw-bw){b_q[bw-1]}, b_q}`.
  - `inst_q <= inst_w` (all bits forwarded). `load_ready_q` is unused.
- `c_q` is held in OS mode.

## Timing
- Reset values: `a_q`, `b_q`, `c_q`, `acc_q`, `inst_q`, `mode_q` = 0; `load_ready_q` = 1.
  - After reset: `out_e = 0`, `inst_e = 0`, `out_s = 0`.
  - Reset overrides everything, including a load, drain or mode change in progress.
- `out_e` and `inst_e` lag `in_w`/`inst_w` by 1 cycle. `out_s` in WS is valid 1 cycle after execute.
- OS accumulate: the result is visible in `acc_q` 1 cycle after the execute cycle.
- OS drain: shift-register semantics. A column of R tiles draining for R consecutive cycles emits bottom row first from the bottom `out_s`. The all-column-tiles-drain-in-same-cycle property holds because instructions enter each row's west edge simultaneously.
- Saturation boundary (`SAT=1`): max + positive stays max; min + negative stays min. `SAT=0` wraps.

## Test plan
- **WS load and execute:** reset; load `in_w=3`; execute `in_w=-2`, `in_n=10` → `out_s=4` next cycle. `inst_e[0]` stays 0 during the absorbed load cycle and forwards the second load pulse.
- **WS rearm:** rearm, then load `in_w=5` → `b_q=5`. A second load without rearm leaves `b_q=5` and forwards `inst_e[0]=1`.
- **OS accumulate:** clear+execute (2,3), then execute (−1,4) and (7,7) → `acc_q=51`. `out_s` shows the forwarded weight each cycle.
- **OS drain:** 3-tile column with accumulators 5/6/7 top→bottom, drain 3 cycles → bottom `out_s` sequence 7, 6, 5. Drain+execute in the same cycle leaves `acc` unchanged by the product.
- **Saturation:** `SAT=1`, psum_bw=16, `acc=32760`, execute (7,7) → 32767. With `SAT=0` → −32727.
- **Mode switch and reset:** WS→OS with `acc` nonzero → `acc_q=0`, `load_ready_q=1`, `inst_w` ignored that cycle. Reset mid-drain → all reset values next edge.
